// File: rtl/nt_pipe_arbiter_if.sv
// Request/response bundle between the Nt_Node requesters and nt_pipe_arbiter.
// Requester k's operands occupy bits [k*W +: W] of req_a/req_b/req_c/req_d.
interface nt_pipe_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_c;
    logic [NREQ*W-1:0] req_d;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/nt_pipe_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage ~(a&b) & ~(c&d) pipe, with flush/drain.
// Optional per-requester grant counters are enabled by defining NT_ARB_STATS_EN.
module nt_pipe_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic                I1470,
    input  logic                I1477,
    nt_pipe_arbiter_if.slave    bus,
    input  logic                flush,
    output logic                busy,
    output logic                flush_done
`ifdef NT_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]  grant_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           flush_done_q, flush_done_d;

    logic           s1_valid_q, s2_valid_q;
    logic [IDW-1:0] s1_id_q, s2_id_q;
    logic [W-1:0]   s1_n1_q, s1_n2_q, s2_data_q;

    logic           stall;
    logic           grant;
    logic [IDW-1:0] gnt_idx;
    logic [W-1:0]   op_a, op_b, op_c, op_d;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                              input int unsigned    off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    assign stall = s2_valid_q & ~bus.resp_ready;

    // State register
    always_ff @(posedge I1470 or posedge I1477) begin
        if (I1477) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    flush_done_d = 1'b1;
                end else if (|bus.req_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StDrain;
                end else if (!(|bus.req_valid) && !s1_valid_q && !s2_valid_q) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // Done once the last result leaves S2 this edge with nothing behind it.
                if (!s1_valid_q && (!s2_valid_q || bus.resp_ready)) begin
                    state_d      = StIdle;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: round-robin grant scan and status
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        if (state_q == StRun && !stall && !flush) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!grant && bus.req_valid[rr_idx(rr_ptr_q, i)]) begin
                    grant   = 1'b1;
                    gnt_idx = rr_idx(rr_ptr_q, i);
                end
            end
        end
        bus.req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
        busy          = (state_q != StIdle) | s1_valid_q | s2_valid_q;
        flush_done    = flush_done_q;
    end

    assign op_a = bus.req_a[32'(gnt_idx)*W +: W];
    assign op_b = bus.req_b[32'(gnt_idx)*W +: W];
    assign op_c = bus.req_c[32'(gnt_idx)*W +: W];
    assign op_d = bus.req_d[32'(gnt_idx)*W +: W];

    // Both stages move together; a stall freezes the whole pipe.
    always_ff @(posedge I1470 or posedge I1477) begin
        if (I1477) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_n1_q    <= '0;
            s1_n2_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= grant;
            if (grant) begin
                s1_id_q <= gnt_idx;
                s1_n1_q <= ~(op_a & op_b);
                s1_n2_q <= ~(op_c & op_d);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_id_q   <= s1_id_q;
                s2_data_q <= s1_n1_q & s1_n2_q;
            end
        end
    end

    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_id    = s2_id_q;
    assign bus.resp_data  = s2_data_q;

`ifdef NT_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q;

    always_ff @(posedge I1470 or posedge I1477) begin
        if (I1477) begin
            cnt_q <= '0;
        end else if (flush_done_q) begin
            cnt_q <= '0;
        end else if (grant && cnt_q[gnt_idx] != 16'hFFFF) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nt_pipe_arbiter.sv
// Directed bench for nt_pipe_arbiter: a cycle-level reference model checked every cycle,
// plus hand-computed expectations for latency, fairness, backpressure and flush.
module tb_nt_pipe_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IDW  = 2;
    localparam int          NR   = 4;

    logic I1470 = 1'b0;
    logic I1477;
    logic flush;
    logic busy;
    logic flush_done;
`ifdef NT_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    nt_pipe_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    nt_pipe_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .I1470      (I1470),
        .I1477      (I1477),
        .bus        (bus),
        .flush      (flush),
        .busy       (busy),
        .flush_done (flush_done)
`ifdef NT_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 I1470 = ~I1470;

    int errors;
    int checks;

    // Stimulus bookkeeping
    logic [W-1:0]    op_a [NR];
    logic [W-1:0]    op_b [NR];
    logic [W-1:0]    op_c [NR];
    logic [W-1:0]    op_d [NR];
    int              target [NR];
    int              acc_cnt [NR];
    logic [NREQ-1:0] extra;
    int              grant_log [$];
    int              resp_log [$];
    int              fd_count;
    int              run_len;
    int              max_run;

    // Reference model: mode 0=idle 1=run 2=drain; pipe as a 2-slot delay line
    int              m_mode;
    int              m_ptr;
    bit              m_v [2];
    int              m_id [2];
    logic [W-1:0]    m_d [2];
    bit              m_fd;
    int              m_cnt [NR];

    function automatic logic [W-1:0] f_op(input logic [W-1:0] a, b, c, d);
        return ~(a & b) & ~(c & d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < NR; k++) begin
            bus.req_valid[k]      = (acc_cnt[k] < target[k]) || extra[k];
            bus.req_a[k*W +: W]   = op_a[k];
            bus.req_b[k*W +: W]   = op_b[k];
            bus.req_c[k*W +: W]   = op_c[k];
            bus.req_d[k*W +: W]   = op_d[k];
        end
    endtask

    task automatic model_cycle();
        bit              stall;
        int              gid;
        bit              nxt_fd;
        logic [NREQ-1:0] exp_ready;
        if (I1477) begin
            m_mode = 0; m_ptr = 0; m_fd = 0;
            for (int s = 0; s < 2; s++) begin m_v[s] = 0; m_id[s] = 0; m_d[s] = '0; end
            for (int k = 0; k < NR; k++) m_cnt[k] = 0;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_id", bus.resp_id, 0);
            chk("rst_resp_data", bus.resp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_flush_done", flush_done, 0);
            run_len = 0;
            return;
        end
        stall = m_v[1] && !bus.resp_ready;
        gid   = -1;
        if (m_mode == 1 && !stall && !flush) begin
            for (int i = 0; i < NR; i++) begin
                int k = (m_ptr + i) % NR;
                if (gid < 0 && bus.req_valid[k]) gid = k;
            end
        end
        exp_ready = (gid >= 0) ? NREQ'(1) << gid : '0;
        chk("m_req_ready", bus.req_ready, exp_ready);
        chk("m_resp_valid", bus.resp_valid, m_v[1]);
        if (m_v[1]) begin
            chk("m_resp_id", bus.resp_id, m_id[1]);
            chk("m_resp_data", bus.resp_data, m_d[1]);
        end
        chk("m_busy", busy, (m_mode != 0) || m_v[0] || m_v[1]);
        chk("m_flush_done", flush_done, m_fd);
`ifdef NT_ARB_STATS_EN
        for (int k = 0; k < NR; k++) chk("m_grant_cnt", grant_cnt[k*16 +: 16], m_cnt[k]);
`endif
        // Observed transfers, for the directed checks
        for (int k = 0; k < NR; k++) begin
            if (bus.req_valid[k] && bus.req_ready[k]) begin
                acc_cnt[k]++;
                grant_log.push_back(k);
            end
        end
        if (bus.resp_valid && bus.resp_ready) resp_log.push_back(int'(bus.resp_id));
        if (flush_done) fd_count++;
        run_len = bus.resp_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        // Advance model to the next edge
        nxt_fd = 0;
        case (m_mode)
            0: if (flush) nxt_fd = 1; else if (bus.req_valid != 0) m_mode = 1;
            1: if (flush) m_mode = 2;
               else if (bus.req_valid == 0 && !m_v[0] && !m_v[1]) m_mode = 0;
            default: if (!m_v[0] && (!m_v[1] || bus.resp_ready)) begin
                m_mode = 0;
                nxt_fd = 1;
            end
        endcase
        for (int k = 0; k < NR; k++) begin
            if (m_fd) m_cnt[k] = 0;
            else if (gid == k && m_cnt[k] < 65535) m_cnt[k]++;
        end
        if (!stall) begin
            m_v[1] = m_v[0]; m_id[1] = m_id[0]; m_d[1] = m_d[0];
            m_v[0] = (gid >= 0);
            if (gid >= 0) begin
                m_id[0] = gid;
                m_d[0]  = f_op(op_a[gid], op_b[gid], op_c[gid], op_d[gid]);
                m_ptr   = (gid + 1) % NR;
            end
        end
        m_fd = nxt_fd;
    endtask

    task automatic tick();
        @(negedge I1470);
        model_cycle();
        @(posedge I1470);
        #1;
        apply();
    endtask

    function automatic bit all_done();
        for (int k = 0; k < NR; k++) if (acc_cnt[k] < target[k]) return 0;
        return 1;
    endfunction

    task automatic wait_acc(input string name, input int bound);
        int n = 0;
        while (!all_done() && n < bound) begin tick(); n++; end
        chk(name, all_done(), 1);
    endtask

    initial begin
        int r0, g0, acc1, acc3, fd0, n;
        errors = 0; checks = 0; fd_count = 0; run_len = 0; max_run = 0;
        extra = '0;
        for (int k = 0; k < NR; k++) begin
            target[k] = 0; acc_cnt[k] = 0;
            op_a[k] = 8'(8'h11 * (k + 1)); op_b[k] = 8'hF0 ^ 8'(k);
            op_c[k] = 8'h3C; op_d[k] = 8'(8'h0F + k);
        end
        I1477 = 1'b1; flush = 1'b0; bus.resp_ready = 1'b1;
        apply();
        tick(); tick();
        I1477 = 1'b0;
        tick();

        // Single request from requester 2
        op_a[2] = 8'hFF; op_b[2] = 8'h0F; op_c[2] = 8'h00; op_d[2] = 8'hAA;
        target[2] = 1; apply();
        wait_acc("t1_accept", 10);
        chk("t1_not_yet", bus.resp_valid, 0);
        tick();
        chk("t1_valid", bus.resp_valid, 1);
        chk("t1_id", bus.resp_id, 2);
        chk("t1_data", bus.resp_data, 8'hF0);
        repeat (3) tick();
        chk("t1_idle_busy", busy, 0);

        // Reset while a response is waiting
        bus.resp_ready = 1'b0; target[1]++; apply();
        wait_acc("rst_accept", 10);
        n = 0;
        while (!bus.resp_valid && n < 5) begin tick(); n++; end
        chk("rst_resp_pending", bus.resp_valid, 1);
        r0 = resp_log.size();
        I1477 = 1'b1;
        #1;
        chk("rst_imm_valid", bus.resp_valid, 0);
        chk("rst_imm_data", bus.resp_data, 0);
        chk("rst_imm_busy", busy, 0);
        tick(); tick();
        I1477 = 1'b0; bus.resp_ready = 1'b1;
        repeat (4) tick();
        chk("rst_no_stale", resp_log.size() - r0, 0);

        // Fairness: all four held for two grants each
        op_a[2] = 8'h33; op_b[2] = 8'hF2; op_c[2] = 8'h3C; op_d[2] = 8'h11;
        g0 = grant_log.size(); r0 = resp_log.size(); max_run = 0;
        for (int k = 0; k < NR; k++) target[k] = acc_cnt[k] + 2;
        apply();
        wait_acc("fair_accept", 30);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            chk("fair_grant_order", (grant_log.size() > g0 + i) ? grant_log[g0 + i] : -1, i % 4);
            chk("fair_resp_order", (resp_log.size() > r0 + i) ? resp_log[r0 + i] : -1, i % 4);
        end
        chk("fair_b2b", max_run, 8);

        // Backpressure: two ops in flight, third request waits
        bus.resp_ready = 1'b0; r0 = resp_log.size();
        target[0]++; target[1]++; apply();
        wait_acc("bp_accept", 10);
        target[2]++; apply();
        repeat (5) begin
            tick();
            chk("bp_ready_zero", bus.req_ready, 0);
        end
        chk("bp_valid_held", bus.resp_valid, 1);
        chk("bp_id_held", bus.resp_id, 0);
        chk("bp_data_held", bus.resp_data, f_op(op_a[0], op_b[0], op_c[0], op_d[0]));
        bus.resp_ready = 1'b1;
        n = 0;
        while (resp_log.size() < r0 + 3 && n < 15) begin tick(); n++; end
        for (int i = 0; i < 3; i++)
            chk("bp_resp_order", (resp_log.size() > r0 + i) ? resp_log[r0 + i] : -1, i);
        repeat (3) tick();

        // Flush with ops 0 and 2 in flight while 1 and 3 request
        r0 = resp_log.size(); fd0 = fd_count;
        target[0]++; target[2]++; apply();
        wait_acc("fl_accept", 10);
        acc1 = acc_cnt[1]; acc3 = acc_cnt[3];
        flush = 1'b1; extra = 4'b1010; apply();
        tick();
        flush = 1'b0;
        n = 0;
        while (!flush_done && n < 10) begin tick(); n++; end
        chk("fl_done_seen", flush_done, 1);
        chk("fl_busy_at_done", busy, 0);
        extra = '0; apply();
        repeat (3) tick();
        chk("fl_done_once", fd_count - fd0, 1);
        chk("fl_no_grant1", acc_cnt[1] - acc1, 0);
        chk("fl_no_grant3", acc_cnt[3] - acc3, 0);
        chk("fl_resp_count", resp_log.size() - r0, 2);
        chk("fl_resp0", (resp_log.size() > r0) ? resp_log[r0] : -1, 0);
        chk("fl_resp1", (resp_log.size() > r0 + 1) ? resp_log[r0 + 1] : -1, 2);
        chk("fl_busy_after", busy, 0);

        // Flush while idle
        flush = 1'b1; apply();
        tick();
        flush = 1'b0;
        chk("fli_pulse", flush_done, 1);
        tick();
        chk("fli_pulse_end", flush_done, 0);
        chk("fli_busy", busy, 0);

`ifdef NT_ARB_STATS_EN
        target[1] += 3; apply();
        wait_acc("st_accept", 20);
        repeat (4) tick();
        chk("st_cnt3", grant_cnt[31:16], 3);
        flush = 1'b1; apply();
        tick();
        flush = 1'b0;
        tick();
        chk("st_cleared", grant_cnt[31:16], 0);
`endif
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
